// File: rtl/prince_seq_ctrl.sv
// Sequencing controller wrapping a combinational unrolled PRINCE core with a multicycle settle window.
// Optional decrypt path enabled by defining PRINCE_DEC_EN.
module prince_seq_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           key_we,
   input  logic [127:0]   key_in,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_dec,
   input  logic [63:0]    plaintext,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [63:0]    ciphertext,
   output logic           busy
);
   localparam int unsigned CNT_W = 4;
   localparam int unsigned BLK_W = 64;
   localparam int unsigned KEY_W = 128;

   localparam logic [3:0] SBOX [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                        4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
   localparam logic [3:0] SINV [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                        4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
   localparam logic [BLK_W-1:0] RC [12] = '{
      64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
      64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
      64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
      64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd};

   if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..15");
   end

   function automatic logic [BLK_W-1:0] f_rot(input logic [BLK_W-1:0] x);
      return {x[0], x[63:1]} ^ {63'b0, x[63]};
   endfunction

   function automatic logic [BLK_W-1:0] sub_nib(input logic [BLK_W-1:0] x, input logic inv);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 16; i++)
         y[4*i +: 4] = inv ? SINV[x[4*i +: 4]] : SBOX[x[4*i +: 4]];
      return y;
   endfunction

   // M' layer: chunks (MSB to LSB) use M^0, M^1, M^1, M^0; nibble/bit indices counted from the MSB
   function automatic logic [BLK_W-1:0] m_prime(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      logic             b;
      int               s;
      y = '0;
      for (int c = 0; c < 4; c++) begin
         s = (c == 1 || c == 2) ? 1 : 0;
         for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
               b = 1'b0;
               for (int k = 0; k < 4; k++)
                  if (((j + k + s) % 4) != i) b = b ^ x[16*c + 4*(3-k) + (3-i)];
               y[16*c + 4*(3-j) + (3-i)] = b;
            end
         end
      end
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] x, input logic inv);
      logic [BLK_W-1:0] y;
      int               q;
      y = '0;
      for (int p = 0; p < 16; p++) begin
         q = (5 * p) % 16;
         if (inv) y[4*(15-q) +: 4] = x[4*(15-p) +: 4];
         else     y[4*(15-p) +: 4] = x[4*(15-q) +: 4];
      end
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] prince_core(input logic [BLK_W-1:0] pt,
                                                     input logic [BLK_W-1:0] k0,
                                                     input logic [BLK_W-1:0] k1);
      logic [BLK_W-1:0] s;
      s = pt ^ k0 ^ k1 ^ RC[0];
      for (int r = 1; r <= 5; r++)
         s = shift_rows(m_prime(sub_nib(s, 1'b0)), 1'b0) ^ RC[r] ^ k1;
      s = sub_nib(m_prime(sub_nib(s, 1'b0)), 1'b1);
      for (int r = 6; r <= 10; r++)
         s = sub_nib(m_prime(shift_rows(s ^ RC[r] ^ k1, 1'b1)), 1'b1);
      return s ^ RC[11] ^ k1 ^ f_rot(k0);
   endfunction

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t            state_q, state_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic [BLK_W-1:0]  blk_q, blk_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BLK_W-1:0]  ct_q, ct_d;
   logic              ov_q, ov_d;
   logic              in_rdy_q, in_rdy_d;
   logic              busy_q, busy_d;
   logic [BLK_W-1:0]  k0, k1, core_k0, core_k1, result;

   assign k0 = key_q[127:64];
   assign k1 = key_q[63:0];

`ifdef PRINCE_DEC_EN
   localparam logic [BLK_W-1:0] ALPHA = 64'hC0AC29B7C97C50DD;
   logic mode_q, mode_d;

   // Decrypt reuses the core with the reflected key; output whitening corrected back to k0
   assign core_k0 = mode_q ? f_rot(k0) : k0;
   assign core_k1 = mode_q ? (k1 ^ ALPHA) : k1;
   assign result  = prince_core(blk_q, core_k0, core_k1) ^ (mode_q ? (f_rot(f_rot(k0)) ^ k0) : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mode_q <= 1'b0;
      else        mode_q <= mode_d;
   end

   always_comb begin
      mode_d = mode_q;
      if (state_q == IDLE && in_valid) mode_d = in_dec;
   end
`else
   logic unused_in_dec;
   assign unused_in_dec = in_dec;
   assign core_k0 = k0;
   assign core_k1 = k1;
   assign result  = prince_core(blk_q, core_k0, core_k1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         key_q    <= '0;
         blk_q    <= '0;
         cnt_q    <= '0;
         ct_q     <= '0;
         ov_q     <= 1'b0;
         in_rdy_q <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         blk_q    <= blk_d;
         cnt_q    <= cnt_d;
         ct_q     <= ct_d;
         ov_q     <= ov_d;
         in_rdy_q <= in_rdy_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      blk_d   = blk_q;
      cnt_d   = cnt_q;
      ct_d    = ct_q;
      ov_d    = ov_q;
      case (state_q)
         IDLE: begin
            if (key_we) key_d = key_in;
            if (in_valid) begin
               blk_d   = plaintext;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               ct_d    = result;
               ov_d    = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_rdy_d = (state_d == IDLE);
      busy_d   = (state_d != IDLE);
   end

   assign in_ready   = in_rdy_q;
   assign out_valid  = ov_q;
   assign ciphertext = ct_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_prince_seq_ctrl.sv
// Directed bench for prince_seq_ctrl: table of PRINCE vectors plus handshake/reset corner sequences.
module tb_prince_seq_ctrl;
   localparam int unsigned S = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          key_we = 1'b0;
   logic [127:0]  key_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_dec = 1'b0;
   logic [63:0]   plaintext = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [63:0]   ciphertext;
   logic          busy;

   int checks = 0;
   int errors = 0;

   prince_seq_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_in(key_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec), .plaintext(plaintext),
      .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] key;
      logic [63:0]  pt;
      logic         dec;
      logic [63:0]  exp;
   } vec_t;

   vec_t vecs[$];

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      @(negedge clk);
      key_we = 1'b1;
      key_in = k;
      @(negedge clk);
      key_we = 1'b0;
   endtask

   task automatic send(input logic [63:0] pt, input logic dec);
      @(negedge clk);
      in_valid  = 1'b1;
      plaintext = pt;
      in_dec    = dec;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts edges after the transfer edge until out_valid is seen; bounded.
   task automatic wait_out(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         n++;
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int n;
      bit ok;
      int xf_cyc[$];
      bit seen;

      vecs.push_back('{{64'h0, 64'h0}, 64'h0000000000000000, 1'b0, 64'h818665AA0D02DFDA});
      vecs.push_back('{{64'h0, 64'h0}, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h604AE6CA03C20ADA});
      vecs.push_back('{{64'hFFFFFFFFFFFFFFFF, 64'h0}, 64'h0, 1'b0, 64'h9FB51935FC3DF524});
      vecs.push_back('{{64'h0, 64'hFFFFFFFFFFFFFFFF}, 64'h0, 1'b0, 64'h78A54CBE737BB7EF});
      vecs.push_back('{{64'h0, 64'hFEDCBA9876543210}, 64'h0123456789ABCDEF, 1'b0, 64'hAE25AD3CA8FA9CCF});
`ifdef PRINCE_DEC_EN
      vecs.push_back('{{64'h0, 64'hFEDCBA9876543210}, 64'hAE25AD3CA8FA9CCF, 1'b1, 64'h0123456789ABCDEF});
`endif

      #1 rst_n = 1'b0;
      #2;
      chk64("rst_in_ready", 64'(in_ready), 64'd1);
      chk64("rst_out_valid", 64'(out_valid), 64'd0);
      chk64("rst_busy", 64'(busy), 64'd0);
      chk64("rst_ciphertext", ciphertext, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         out_ready = 1'b1;
         load_key(vecs[i].key);
         send(vecs[i].pt, vecs[i].dec);
         chk64($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
         chk64($sformatf("v%0d_in_ready_low", i), 64'(in_ready), 64'd0);
         wait_out(n, ok);
         chk_int($sformatf("v%0d_latency", i), ok ? n + 1 : -1, S + 1);
         chk64($sformatf("v%0d_ct", i), ciphertext, vecs[i].exp);
         @(posedge clk);
         #1;
         chk64($sformatf("v%0d_back_idle", i), {62'b0, in_ready, out_valid}, 64'b10);
      end

      // Stall downstream: result stable, key writes ignored
      load_key(128'h0);
      out_ready = 1'b0;
      send(64'h0, 1'b0);
      wait_out(n, ok);
      chk_int("hold_latency", ok ? n + 1 : -1, S + 1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         key_we = c[0];
         key_in = {128{1'b1}};
         @(posedge clk);
         #1;
         chk64($sformatf("hold%0d_ov", c), 64'(out_valid), 64'd1);
         chk64($sformatf("hold%0d_ct", c), ciphertext, 64'h818665AA0D02DFDA);
         chk64($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      key_we = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk64("release_idle", {61'b0, in_ready, out_valid, busy}, 64'b100);
      send(64'hFFFFFFFFFFFFFFFF, 1'b0);
      wait_out(n, ok);
      chk64("old_key_kept", ok ? ciphertext : 64'hDEAD, 64'h604AE6CA03C20ADA);
      @(posedge clk);
      #1;

      // Key write and block transfer in the same cycle: new key applies
      load_key({128{1'b1}});
      @(negedge clk);
      key_we = 1'b1;
      key_in = 128'h0;
      in_valid = 1'b1;
      plaintext = 64'h0;
      in_dec = 1'b0;
      @(posedge clk);
      #1;
      key_we = 1'b0;
      in_valid = 1'b0;
      wait_out(n, ok);
      chk64("same_cycle_key", ok ? ciphertext : 64'hDEAD, 64'h818665AA0D02DFDA);
      @(posedge clk);
      #1;

      // Reset during SETTLE aborts the block
      load_key({128{1'b1}});
      send(64'h0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk64("abort_state", {61'b0, in_ready, out_valid, busy}, 64'b100);
      chk64("abort_ct", ciphertext, 64'h0);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < S + 4; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk64("abort_no_valid", 64'(seen), 64'd0);
      send(64'h0, 1'b0);
      wait_out(n, ok);
      chk_int("after_abort_latency", ok ? n + 1 : -1, S + 1);
      chk64("after_abort_ct", ciphertext, 64'h818665AA0D02DFDA);
      @(posedge clk);
      #1;

      // Back-to-back blocks with out_ready high
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      plaintext = 64'h0;
      for (int c = 0; c < 60 && xf_cyc.size() < 3; c++) begin
         if (in_ready) xf_cyc.push_back(c);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk_int("b2b_count", xf_cyc.size(), 3);
      if (xf_cyc.size() == 3) begin
         chk_int("b2b_gap0", xf_cyc[1] - xf_cyc[0], S + 2);
         chk_int("b2b_gap1", xf_cyc[2] - xf_cyc[1], S + 2);
      end
      repeat (S + 3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
